// File: rtl/crossing_pkg.sv
// Shared state encoding and default timing constants for the level crossing controller.
package crossing_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ALERT  = 2'b01,
    CLOSED = 2'b10
  } state_t;

  localparam int DEF_N_TRACKS      = 2;
  localparam int DEF_ALERT_CYC     = 10;
  localparam int DEF_CLOSE_MIN_CYC = 4;
  localparam int DEF_MAX_CLOSE_CYC = 200;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/crossing_sync.sv
// Two-flop synchroniser for the asynchronous track occupancy sensors.
module crossing_sync
  import crossing_pkg::*;
#(
  parameter int WIDTH = DEF_N_TRACKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  // stage p0 captures the raw sensor, stage p1 resolves metastability
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/level_crossing_ctrl.sv
// Level crossing controller: warning phase, barrier closure, stuck-occupancy fault.
// Optional flashing warning lamp when LEVEL_CROSSING_FLASH_EN is defined.
module level_crossing_ctrl
  import crossing_pkg::*;
#(
  parameter int N_TRACKS      = DEF_N_TRACKS,
  parameter int ALERT_CYC     = DEF_ALERT_CYC,
  parameter int CLOSE_MIN_CYC = DEF_CLOSE_MIN_CYC,
  parameter int MAX_CLOSE_CYC = DEF_MAX_CLOSE_CYC,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_TRACKS-1:0] occ,
  output logic                alert_led,
  output logic                barrier_down,
  output logic                fault,
  output logic [7:0]          closures
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] ALERT_LAST = CNT_W'(ALERT_CYC - 1);
  localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_MIN_CYC - 1);
  localparam logic [CNT_W-1:0] FAULT_CNT  = CNT_W'(MAX_CLOSE_CYC);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_ONE;
  endfunction

  logic [N_TRACKS-1:0] occ_s;
  logic                any_occ;
  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                closure_inc;
  logic                fault_set;

  crossing_sync #(.WIDTH(N_TRACKS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (occ),
    .q     (occ_s)
  );

  assign any_occ = |occ_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      fault    <= 1'b0;
      closures <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (fault_set)   fault    <= 1'b1;
      if (closure_inc) closures <= closures + 8'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    closure_inc = 1'b0;
    fault_set   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (any_occ) state_nxt = ALERT;
      end
      ALERT: begin
        // occupancy is deliberately ignored until the warning has run its course
        if (cnt == ALERT_LAST) begin
          state_nxt = CLOSED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      CLOSED: begin
        fault_set = any_occ && (cnt == FAULT_CNT);
        if ((cnt >= CLOSE_LAST) && !any_occ) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          closure_inc = 1'b1;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    barrier_down = (state == CLOSED);
`ifdef LEVEL_CROSSING_FLASH_EN
    // counter restarts at 0 on ALERT entry, so bit 1 gives a 2-on/2-off flash
    alert_led = (state == ALERT) && !cnt[1];
`else
    alert_led = (state == ALERT);
`endif
  end

endmodule

// File: tb/tb_level_crossing_ctrl.sv
// Self-checking bench for level_crossing_ctrl: directed scenarios plus random occupancy vs. a phase model.
module tb_level_crossing_ctrl;

  localparam int ALERT_CYC = 10;
  localparam int CLOSE_MIN = 4;
  localparam int MAX_CLOSE = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] occ = 2'b00;
  logic       alert_led, barrier_down, fault;
  logic [7:0] closures;

  int tests = 0;
  int fails = 0;
  int n_alert = 0;
  int n_bar = 0;

  // phase model: warning progress, closure age, sticky fault, closure tally
  bit m_h1, m_h2;
  bit m_alerting, m_closed, m_fault;
  int m_idx, m_age, m_closures;

  level_crossing_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .occ          (occ),
    .alert_led    (alert_led),
    .barrier_down (barrier_down),
    .fault        (fault),
    .closures     (closures)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_alert();
`ifdef LEVEL_CROSSING_FLASH_EN
    return m_alerting && ((m_idx / 2) % 2 == 0);
`else
    return m_alerting;
`endif
  endfunction

  initial begin : model
    bit a;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_h1 = 0; m_h2 = 0; m_alerting = 0; m_closed = 0; m_fault = 0;
        m_idx = 0; m_age = 0; m_closures = 0;
      end else begin
        a = m_h2;
        m_h2 = m_h1;
        m_h1 = |occ;
        if (m_closed) begin
          if (m_age >= CLOSE_MIN - 1 && !a) begin
            m_closed = 0;
            m_closures = (m_closures + 1) % 256;
          end else begin
            if (a && m_age == MAX_CLOSE) m_fault = 1;
            m_age++;
          end
        end else if (m_alerting) begin
          m_idx++;
          if (m_idx == ALERT_CYC) begin
            m_alerting = 0;
            m_closed = 1;
            m_age = 0;
          end
        end else if (a) begin
          m_alerting = 1;
          m_idx = 0;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        chk("rst_alert", alert_led, 0);
        chk("rst_barrier", barrier_down, 0);
        chk("rst_fault", fault, 0);
        chk("rst_closures", closures, 0);
      end else begin
        chk("alert_led", alert_led, exp_alert());
        chk("barrier_down", barrier_down, m_closed);
        chk("fault", fault, m_fault);
        chk("closures", closures, m_closures);
        if (alert_led && barrier_down) chk("exclusive", 1, 0);
      end
    end
  end

  task automatic hold(input logic [1:0] v, input int n);
    repeat (n) begin
      @(negedge clk);
      occ = v;
      if (alert_led) n_alert++;
      if (barrier_down) n_bar++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    occ = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_alert = 0;
    n_bar = 0;
  endtask

`ifdef LEVEL_CROSSING_FLASH_EN
  localparam int ALERT_ON = 6;
`else
  localparam int ALERT_ON = 10;
`endif

  initial begin : stim
    do_reset();

    // long train
    hold(2'b01, 30);
    hold(2'b00, 30);
    chk("s1_alert_cycles", n_alert, ALERT_ON);
    chk("s1_barrier_cycles", n_bar, 20);
    chk("s1_closures", closures, 1);

    // short pulse
    do_reset();
    hold(2'b01, 3);
    hold(2'b00, 30);
    chk("s2_alert_cycles", n_alert, ALERT_ON);
    chk("s2_barrier_cycles", n_bar, 4);
    chk("s2_barrier_off", barrier_down, 0);

    // second train arrives during warning
    do_reset();
    hold(2'b01, 7);
    hold(2'b11, 5);
    hold(2'b10, 40);
    hold(2'b00, 20);
    chk("s3_alert_cycles", n_alert, ALERT_ON);
    chk("s3_barrier_cycles", n_bar, 42);
    chk("s3_closures", closures, 1);

    // stuck occupancy
    do_reset();
    hold(2'b01, 300);
    chk("s4_fault_set", fault, 1);
    chk("s4_barrier_held", barrier_down, 1);
    hold(2'b00, 20);
    chk("s4_fault_sticky", fault, 1);
    chk("s4_barrier_up", barrier_down, 0);
    do_reset();
    chk("s4_fault_cleared", fault, 0);

    // reset in the middle of the warning
    @(negedge clk);
    occ = 2'b01;
    repeat (8) @(posedge clk);
    chk("s5_in_alert", barrier_down == 0 && fault == 0 && dut.state == 2'b01, 1);
    #2 reset = 1'b1;
    #1;
    chk("s5_async_alert", alert_led, 0);
    chk("s5_async_barrier", barrier_down, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_alert = 0;
    n_bar = 0;
    hold(2'b01, 20);
    hold(2'b00, 20);
    chk("s5_fresh_alert", n_alert, ALERT_ON);

    // closure counter wrap
    do_reset();
    repeat (260) begin
      hold(2'b01, 2);
      hold(2'b00, 20);
    end
    chk("s6_wrap", closures, 4);

    // random occupancy with occasional resets
    do_reset();
    repeat (400) begin
      if ($urandom_range(49) == 0) do_reset();
      hold(2'($urandom_range(3)), int'($urandom_range(40, 1)));
    end
    hold(2'b00, 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
